serial_wide_adder: RTL and testbench
====================================

// Module: serial_wide_adder
// PURPOSE
//  Multi-cycle WIDTH-bit adder built around one 4-bit carry-select slice.
//  Captures operands over a valid/ready handshake and feeds the slice one 4-bit chunk per cycle, LSB first.
//  Registers the inter-slice carry and assembles the sum, then presents result+flags downstream over valid/ready.
//  Sits between the operand source and the slice; trades latency for area vs a full-width adder.
// PARAMETERS
//  WIDTH   32  operand/sum width; must be a multiple of 4, >= 8
//  NSLICE  WIDTH/4 (localparam, derived)  number of slice cycles per operation
// PORTS
//  in_clk    input   1      clock, all state on rising edge
//  in_rst    input   1      asynchronous reset, active-high
//  in_valid  input   1      upstream operands valid
//  out_ready output  1      block can accept operands
//  in_A      input   WIDTH  operand A
//  in_B      input   WIDTH  operand B
//  in_C      input   1      carry-in
//  out_valid output  1      result valid
//  in_ready  input   1      downstream accepts result
//  out_S     output  WIDTH  sum
//  out_C     output  1      carry-out of MSB
//  out_V     output  1      signed overflow (carry into MSB ^ carry out of MSB)
// BEHAVIOUR
//  Reset (async, in_rst=1): state=IDLE, cnt=0, carry=0, out_S=0, out_C=0, out_V=0, out_valid=0; out_ready forced 0 while in_rst=1.
//  FSM states: IDLE, RUN, DONE.
//  IDLE: out_ready=1. On in_valid & out_ready: latch A, B, in_C into carry; cnt<=0; -> RUN.
//  RUN: out_ready=0. Each edge: slice cnt adds A[4cnt+3:4cnt] + B[...] + carry.
//   Writes S[4cnt+3:4cnt]; carry<=slice cout; cnt<=cnt+1.
//   On cnt==NSLICE-1: out_C<=cout; out_V<=c_into_msb^cout; -> DONE.
//  DONE: out_valid=1; out_S/out_C/out_V held stable. On in_ready: -> IDLE, out_valid=0 next cycle.
//  Latency: out_valid rises exactly NSLICE cycles after the accepting edge.
//  Throughput: one op per NSLICE+2 cycles (no overlap; out_ready=0 outside IDLE).
//  in_valid/in_A/in_B ignored outside IDLE; operands are used only from the latched copy.
//  Arithmetic: modulo 2^WIDTH; {out_C,out_S} == A+B+in_C exactly. Carry chain never wraps; cnt saturates at NSLICE-1.
//  Reset mid-RUN or mid-DONE: operation discarded, no out_valid pulse. out_ready=1 the first cycle after in_rst falls.
//  in_ready high while not in DONE: no effect.
//  out_S contents outside DONE are unspecified.
// STRUCTURE
//  Shared include csa_defs.vh:
//   SLICE_W=4; state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//  Sub-module csa4_slice (combinational): 4-bit carry-select slice.
//   Two ripple paths precomputed for cin=0/1, output muxed by cin.
//   Ports: a[3:0], b[3:0], cin -> s[3:0], cout, c3 (carry into bit 3, for overflow).
//  Top: FSM, cnt, operand regs, carry reg, result reg, chunk select muxes.
// TESTING
//  1 WIDTH=32, A=0xFFFFFFFF, B=0x1, C=0 -> S=0x00000000, C=1, V=0; out_valid exactly 8 cycles after accept.
//  2 A=0x7FFFFFFF, B=0x1, C=0 -> S=0x80000000, C=0, V=1.
//  3 A=B=0x12345678, C=1 -> S=0x2468ACF1, C=0, V=0.
//  4 Backpressure: hold in_ready=0 for 5 cycles in DONE.
//   -> out_valid/out_S stable, out_ready=0; an in_valid pulse there is not accepted.
//  5 Assert in_rst during RUN at cnt=3 -> no out_valid; out_ready=1 after release; next op (A=5, B=3) gives S=8.
//  6 WIDTH=8 and 32: 1000 random A/B/C with random in_valid/in_ready -> every result == A+B+C model, no lost or duplicated ops.

Source files
------------

// File: rtl/serial_wide_adder_pkg.sv
// Shared definitions for the serial wide adder: slice width, FSM states
// and the overflow helper used at the most significant slice.
package serial_wide_adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    function automatic logic ovf(input logic c_into_msb, input logic c_out);
        return c_into_msb ^ c_out;
    endfunction

endpackage

// File: rtl/csa4_slice.sv
// 4-bit carry-select slice: both carry-in outcomes are formed up front
// and the real carry-in only steers the final mux.
module csa4_slice
    import serial_wide_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout,
    output logic               c3
);

    logic [SLICE_W:0]   sum0;
    logic [SLICE_W:0]   sum1;
    logic [SLICE_W-1:0] low0;
    logic [SLICE_W-1:0] low1;

    always_comb begin
        sum0 = {1'b0, a} + {1'b0, b};
        sum1 = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, 1'b1};
        // Low three bits alone give the carry into bit 3.
        low0 = {1'b0, a[SLICE_W-2:0]} + {1'b0, b[SLICE_W-2:0]};
        low1 = {1'b0, a[SLICE_W-2:0]} + {1'b0, b[SLICE_W-2:0]}
             + {{(SLICE_W-1){1'b0}}, 1'b1};
    end

    always_comb begin
        s    = cin ? sum1[SLICE_W-1:0] : sum0[SLICE_W-1:0];
        cout = cin ? sum1[SLICE_W] : sum0[SLICE_W];
        c3   = cin ? low1[SLICE_W-1] : low0[SLICE_W-1];
    end

endmodule

// File: rtl/serial_wide_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit slice walks the operands LSB
// first, carrying between cycles through a register.
module serial_wide_adder
    import serial_wide_adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_valid,
    output logic             out_ready,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic             in_C,
    output logic             out_valid,
    input  logic             in_ready,
    output logic [WIDTH-1:0] out_S,
    output logic             out_C,
    output logic             out_V
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CW = $clog2(NSLICE);
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    state_t state;
    state_t state_nx;

    logic [CW-1:0]      cnt;
    logic [CW+1:0]      base;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic               res_c;
    logic               res_v;
    logic               accept;
    logic               last;
    logic [SLICE_W-1:0] a_chunk;
    logic [SLICE_W-1:0] b_chunk;
    logic [SLICE_W-1:0] s_chunk;
    logic               slice_cout;
    logic               slice_c3;

    assign out_ready = (state == ST_IDLE) && !in_rst;
    assign accept    = in_valid && out_ready;
    assign last      = (cnt == LAST);
    assign base      = {cnt, 2'b00};
    assign a_chunk   = op_a[base +: SLICE_W];
    assign b_chunk   = op_b[base +: SLICE_W];

    assign out_S = sum;
    assign out_C = res_c;
    assign out_V = res_v;

    csa4_slice u_slice (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry),
        .s    (s_chunk),
        .cout (slice_cout),
        .c3   (slice_c3)
    );

    always_comb begin
        state_nx  = state;
        out_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (last) state_nx = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (in_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            cnt   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            sum   <= '0;
            res_c <= 1'b0;
            res_v <= 1'b0;
        end else if (accept) begin
            op_a  <= in_A;
            op_b  <= in_B;
            carry <= in_C;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            sum[base +: SLICE_W] <= s_chunk;
            carry <= slice_cout;
            // Counter holds at the last slice; flags come from that slice only.
            if (last) begin
                res_c <= slice_cout;
                res_v <= ovf(slice_c3, slice_cout);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_wide_adder.sv
// Self-checking bench for serial_wide_adder at WIDTH=32 and WIDTH=8.
// Directed vectors, handshake corner cases and a randomized scoreboard.
module tb_serial_wide_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        iready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sel8;

    logic        r32, v32, c32, o32;
    logic [31:0] s32;
    logic        r8, v8, c8, o8;
    logic [7:0]  s8;

    logic        m_ready, m_valid, m_c, m_v;
    logic [31:0] m_s;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_wide_adder #(.WIDTH(32)) dut32 (
        .in_clk    (clk),
        .in_rst    (rst),
        .in_valid  (valid && !sel8),
        .out_ready (r32),
        .in_A      (a),
        .in_B      (b),
        .in_C      (cin),
        .out_valid (v32),
        .in_ready  (iready && !sel8),
        .out_S     (s32),
        .out_C     (c32),
        .out_V     (o32)
    );

    serial_wide_adder #(.WIDTH(8)) dut8 (
        .in_clk    (clk),
        .in_rst    (rst),
        .in_valid  (valid && sel8),
        .out_ready (r8),
        .in_A      (a[7:0]),
        .in_B      (b[7:0]),
        .in_C      (cin),
        .out_valid (v8),
        .in_ready  (iready && sel8),
        .out_S     (s8),
        .out_C     (c8),
        .out_V     (o8)
    );

    always_comb begin
        m_ready = sel8 ? r8 : r32;
        m_valid = sel8 ? v8 : v32;
        m_s     = sel8 ? {24'h0, s8} : s32;
        m_c     = sel8 ? c8 : c32;
        m_v     = sel8 ? o8 : o32;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns just after the accepting edge, with in_valid dropped.
    task automatic accept_op(input logic [31:0] ia, input logic [31:0] ib,
                             input logic ic);
        int n;
        @(posedge clk);
        #1;
        a = ia;
        b = ib;
        cin = ic;
        valid = 1'b1;
        iready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!m_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        valid = 1'b0;
        a = $urandom;
        b = $urandom;
        cin = 1'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!m_valid && lat < 100);
        if (lat >= 100) check("result_timeout", 1, 0);
    endtask

    // Called at a negedge while out_valid is high.
    task automatic consume();
        iready = 1'b1;
        @(posedge clk);
        #1;
        iready = 1'b0;
    endtask

    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib,
                         input logic ic, output logic [31:0] rs,
                         output logic rc, output logic rv, output int lat);
        accept_op(ia, ib, ic);
        wait_result(lat);
        rs = m_s;
        rc = m_c;
        rv = m_v;
        consume();
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [31:0] s;
        logic        co;
        logic        v;
    } vec_t;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
    } res_t;

    function automatic res_t model(input int w, input logic [31:0] ia,
                                   input logic [31:0] ib, input logic ic);
        res_t r;
        longint unsigned mask;
        longint unsigned ua, ub, us;
        longint sa, sb, ss, half;
        mask = (64'd1 << w) - 1;
        ua = longint'(ia) & mask;
        ub = longint'(ib) & mask;
        us = ua + ub + longint'(ic);
        half = longint'(1) << (w - 1);
        sa = (ua >= half) ? longint'(ua) - 2 * half : longint'(ua);
        sb = (ub >= half) ? longint'(ub) - 2 * half : longint'(ub);
        ss = sa + sb + longint'(ic);
        r.s = 32'(us & mask);
        r.c = 1'((us >> w) & 1);
        r.v = (ss >= half) || (ss < -half);
        return r;
    endfunction

    task automatic run_random(input int w, input int nops);
        res_t q[$];
        res_t exp;
        int sent;
        int got;
        int cyc;
        sel8 = (w == 8);
        sent = 0;
        got = 0;
        cyc = 0;
        while (got < nops && cyc < nops * 50) begin
            @(posedge clk);
            #1;
            valid = (sent < nops) && ($urandom_range(0, 3) != 0);
            a = $urandom;
            b = $urandom;
            cin = 1'($urandom);
            iready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            cyc++;
            if (valid && m_ready) begin
                q.push_back(model(w, a, b, cin));
                sent++;
            end
            if (m_valid && iready) begin
                if (q.size() == 0) begin
                    check($sformatf("rand%0d_spurious", w), 1, 0);
                end else begin
                    exp = q.pop_front();
                    check($sformatf("rand%0d_result", w),
                          {m_c, m_v, m_s}, {exp.c, exp.v, exp.s});
                end
                got++;
            end
        end
        valid = 1'b0;
        iready = 1'b0;
        check($sformatf("rand%0d_count", w), got, nops);
        check($sformatf("rand%0d_pending", w), q.size(), 0);
        sel8 = 1'b0;
    endtask

    initial begin
        vec_t vecs[7];
        logic [31:0] rs;
        logic rc, rv;
        int lat;
        logic seen;

        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[2] = '{32'h12345678, 32'h12345678, 1'b1, 32'h2468ACF1, 1'b0, 1'b0};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[4] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[6] = '{32'h0FFFFFFF, 32'h00000001, 1'b0, 32'h10000000, 1'b0, 1'b0};

        rst = 1'b1;
        valid = 1'b0;
        iready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        sel8 = 1'b0;

        @(negedge clk);
        check("reset_ready32", r32, 0);
        check("reset_valid32", v32, 0);
        check("reset_flags32", {c32, o32, s32}, 0);
        check("reset_ready8", r8, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_reset", r32, 1);

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].c, rs, rc, rv, lat);
            check($sformatf("vec%0d_sum", i), rs, vecs[i].s);
            check($sformatf("vec%0d_flags", i), {rc, rv}, {vecs[i].co, vecs[i].v});
            check($sformatf("vec%0d_latency", i), lat, 8);
        end
        @(negedge clk);
        check("idle_after_consume", {v32, r32}, 2'b01);

        // Backpressure: result held for 5 cycles, stray in_valid ignored.
        accept_op(32'h11111111, 32'h22222222, 1'b0);
        wait_result(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            valid = (i == 2);
            a = 32'hAAAAAAAA;
            b = 32'h55555555;
            @(negedge clk);
            check($sformatf("bp%0d_hold", i), {m_valid, m_ready, m_s},
                  {1'b1, 1'b0, 32'h33333333});
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(negedge clk);
        check("bp_still_held", {m_valid, m_s}, {1'b1, 32'h33333333});
        consume();
        @(negedge clk);
        check("bp_released", {m_valid, m_ready}, 2'b01);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen |= m_valid;
        end
        check("bp_no_extra_op", seen, 0);

        // Reset in the middle of RUN with cnt at 3.
        accept_op(32'hDEADBEEF, 32'h01234567, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrun_rst_outs", {m_ready, m_valid}, 2'b00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrun_ready_after", m_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen |= m_valid;
        end
        check("midrun_no_valid", seen, 0);
        do_op(32'd5, 32'd3, 1'b0, rs, rc, rv, lat);
        check("after_rst_sum", {rc, rv, rs}, {1'b0, 1'b0, 32'd8});

        run_random(32, 1000);
        run_random(8, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
